// File: rtl/intrusion_pkg.sv
// Shared types and defaults for the intrusion detector slice: FSM state encoding,
// zone-mask type, default timing constants and the delay-counter width helper.
package intrusion_pkg;

  localparam int DEF_NUM_ZONES       = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 8;
  localparam int DEF_EXIT_DELAY      = 16;
  localparam int DEF_ENTRY_DELAY     = 16;
  localparam logic [DEF_NUM_ZONES-1:0] DEF_ENTRY_ZONE_MASK = 4'b0001;

  typedef enum logic [2:0] {
    ST_DISARMED    = 3'd0,
    ST_EXIT_DELAY  = 3'd1,
    ST_ARMED       = 3'd2,
    ST_ENTRY_DELAY = 3'd3,
    ST_ALARM       = 3'd4
  } state_t;

  typedef logic [DEF_NUM_ZONES-1:0] zone_mask_t;

  // Counter holds at most max(delay)-1, so clog2(max) bits suffice (never below 1).
  function automatic int dcnt_width(input int exit_d, input int entry_d);
    int m;
    m = (exit_d > entry_d) ? exit_d : entry_d;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/intrusion_if.sv
// Sensor/request inputs and alert/status outputs of the intrusion detector,
// grouped as one bus; master drives the requests, slave is the detector.
interface intrusion_if
  import intrusion_pkg::*;
#(
  parameter int NUM_ZONES = DEF_NUM_ZONES
);
  logic [NUM_ZONES-1:0] sensor_raw;
  logic                 arm_req;
  logic                 disarm_req;
  logic                 tamper;
  logic                 intruder_detected;
  logic                 system_compromised;
  logic                 armed;
  logic                 delay_active;
  logic                 arm_fault;
  logic [2:0]           state_o;
  logic [NUM_ZONES-1:0] tripped_zones;

  modport master (
    output sensor_raw, arm_req, disarm_req, tamper,
    input  intruder_detected, system_compromised, armed, delay_active,
           arm_fault, state_o, tripped_zones
  );

  modport slave (
    input  sensor_raw, arm_req, disarm_req, tamper,
    output intruder_detected, system_compromised, armed, delay_active,
           arm_fault, state_o, tripped_zones
  );
endinterface

// File: rtl/zone_debouncer.sv
// Two-flop synchroniser followed by a stability counter; the debounced level
// follows the synced input only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
module zone_debouncer #(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic [CW-1:0] cnt_r;

  // Synchronise, then count disagreeing cycles; the Nth one commits the new level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      cnt_r   <= '0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
      if (sync2_r != level_r) begin
        if (cnt_r == CW'(DEBOUNCE_CYCLES - 1)) begin
          level_r <= sync2_r;
          cnt_r   <= '0;
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end else begin
        cnt_r <= '0;
      end
    end
  end

  assign level = level_r;
endmodule

// File: rtl/intrusion_detector.sv
// Zone debounce, arming FSM with exit/entry delays and latched tripped-zone mask.
// Build option: define INTRUSION_TAMPER_EN to debounce tamper into system_compromised.
module intrusion_detector
  import intrusion_pkg::*;
#(
  parameter int NUM_ZONES       = DEF_NUM_ZONES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int EXIT_DELAY      = DEF_EXIT_DELAY,
  parameter int ENTRY_DELAY     = DEF_ENTRY_DELAY,
  parameter logic [NUM_ZONES-1:0] ENTRY_ZONE_MASK = NUM_ZONES'(DEF_ENTRY_ZONE_MASK)
) (
  input  logic       clk,
  input  logic       rst,
  intrusion_if.slave bus
);
  localparam int DW = dcnt_width(EXIT_DELAY, ENTRY_DELAY);

  logic [NUM_ZONES-1:0] zones_s;
  logic [NUM_ZONES-1:0] tripped_r;
  state_t               state_r;
  state_t               next_state_s;
  logic [DW-1:0]        dcnt_r;
  logic [DW-1:0]        next_dcnt_s;
  logic                 arm_fault_r;
  logic                 compromised_r;
  logic                 instant_hit_s;
  logic                 entry_hit_s;
  logic                 intruder_s;
  logic                 armed_s;
  logic                 delay_s;

  for (genvar g = 0; g < NUM_ZONES; g++) begin : g_zone
    zone_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .raw   (bus.sensor_raw[g]),
      .level (zones_s[g])
    );
  end

  assign instant_hit_s = |(zones_s & ~ENTRY_ZONE_MASK);
  assign entry_hit_s   = |(zones_s & ENTRY_ZONE_MASK);

  // FSM state and delay counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_DISARMED;
      dcnt_r  <= '0;
    end else begin
      state_r <= next_state_s;
      dcnt_r  <= next_dcnt_s;
    end
  end

  // Next-state logic; disarm overrides every other request
  always_comb begin
    next_state_s = state_r;
    next_dcnt_s  = dcnt_r;
    if (bus.disarm_req) begin
      next_state_s = ST_DISARMED;
      next_dcnt_s  = '0;
    end else begin
      case (state_r)
        ST_DISARMED: begin
          if (bus.arm_req && (zones_s == '0)) begin
            next_state_s = ST_EXIT_DELAY;
            next_dcnt_s  = DW'(EXIT_DELAY - 1);
          end else begin
            next_state_s = ST_DISARMED;
          end
        end
        ST_EXIT_DELAY: begin
          if (dcnt_r == '0) next_state_s = ST_ARMED;
          else              next_dcnt_s  = dcnt_r - DW'(1);
        end
        ST_ARMED: begin
          if (instant_hit_s) begin
            next_state_s = ST_ALARM;
          end else if (entry_hit_s) begin
            next_state_s = ST_ENTRY_DELAY;
            next_dcnt_s  = DW'(ENTRY_DELAY - 1);
          end else begin
            next_state_s = ST_ARMED;
          end
        end
        ST_ENTRY_DELAY: begin
          if (instant_hit_s || (dcnt_r == '0)) next_state_s = ST_ALARM;
          else                                 next_dcnt_s  = dcnt_r - DW'(1);
        end
        ST_ALARM: next_state_s = ST_ALARM;
        default: begin
          next_state_s = ST_DISARMED;
          next_dcnt_s  = '0;
        end
      endcase
    end
  end

  // Refused-arm pulse and tripped-zone latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arm_fault_r <= 1'b0;
      tripped_r   <= '0;
    end else begin
      arm_fault_r <= (state_r == ST_DISARMED) && bus.arm_req && !bus.disarm_req &&
                     (zones_s != '0);
      if (bus.disarm_req)                tripped_r <= '0;
      else if (next_state_s == ST_ALARM) tripped_r <= tripped_r | zones_s;
      else                               tripped_r <= tripped_r;
    end
  end

  // Status decode straight from the state register
  always_comb begin
    intruder_s = 1'b0;
    armed_s    = 1'b0;
    delay_s    = 1'b0;
    case (state_r)
      ST_DISARMED:    ;
      ST_EXIT_DELAY:  delay_s = 1'b1;
      ST_ARMED:       armed_s = 1'b1;
      ST_ENTRY_DELAY: begin armed_s = 1'b1; delay_s = 1'b1; end
      ST_ALARM:       begin armed_s = 1'b1; intruder_s = 1'b1; end
      default:        ;
    endcase
  end

`ifdef INTRUSION_TAMPER_EN
  logic tamper_level_s;

  zone_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_tamper_deb (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.tamper),
    .level (tamper_level_s)
  );

  // Sticky compromise flag; disarm only clears it once tamper has settled low
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 compromised_r <= 1'b0;
    else if (tamper_level_s) compromised_r <= 1'b1;
    else if (bus.disarm_req) compromised_r <= 1'b0;
    else                     compromised_r <= compromised_r;
  end
`else
  logic unused_tamper_s;
  assign unused_tamper_s = bus.tamper;
  assign compromised_r   = 1'b0;
`endif

  assign bus.intruder_detected  = intruder_s;
  assign bus.armed              = armed_s;
  assign bus.delay_active       = delay_s;
  assign bus.arm_fault          = arm_fault_r;
  assign bus.state_o            = state_r;
  assign bus.tripped_zones      = tripped_r;
  assign bus.system_compromised = compromised_r;
endmodule

// File: tb/tb_intrusion_detector.sv
// Directed, table-driven bench for intrusion_detector with hand-computed expectations,
// plus sequences for asynchronous reset mid-delay and tamper handling.
module tb_intrusion_detector;
  import intrusion_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  intrusion_if #(.NUM_ZONES(4)) bus ();

  intrusion_detector dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string        name;
    logic [3:0]   sensor;
    logic         arm;
    logic         disarm;
    int           ncyc;
    logic [11:0]  exp;
  } vec_t;

  vec_t vecs[$];

  // {state, armed, delay_active, intruder, arm_fault, tripped[3:0], compromised}
  function automatic logic [11:0] ex(input state_t st, input logic a, input logic d,
                                     input logic i, input logic f, input logic [3:0] t,
                                     input logic c);
    return {st, a, d, i, f, t, c};
  endfunction

  function automatic logic [11:0] obs();
    return {bus.state_o, bus.armed, bus.delay_active, bus.intruder_detected,
            bus.arm_fault, bus.tripped_zones, bus.system_compromised};
  endfunction

  task automatic add(input string n, input logic [3:0] s, input logic a, input logic d,
                     input int c, input logic [11:0] e);
    vec_t v;
    v.name = n; v.sensor = s; v.arm = a; v.disarm = d; v.ncyc = c; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string n, input logic [11:0] e);
    logic [11:0] a;
    a = obs();
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    bus.sensor_raw = 4'b0000;
    bus.arm_req    = 1'b0;
    bus.disarm_req = 1'b0;
    bus.tamper     = 1'b0;

    add("arm_ok",      4'b0000, 1'b1, 1'b0, 1,  ex(ST_EXIT_DELAY, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0));
    add("exit_mid",    4'b0000, 1'b0, 1'b0, 14, ex(ST_EXIT_DELAY, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0));
    add("exit_last",   4'b0000, 1'b0, 1'b0, 1,  ex(ST_EXIT_DELAY, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0));
    add("armed",       4'b0000, 1'b0, 1'b0, 1,  ex(ST_ARMED,      1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0));
    add("pulse5",      4'b0100, 1'b0, 1'b0, 5,  ex(ST_ARMED,      1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0));
    add("pulse_gone",  4'b0000, 1'b0, 1'b0, 20, ex(ST_ARMED,      1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0));
    add("z2_edge10",   4'b0100, 1'b0, 1'b0, 10, ex(ST_ARMED,      1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0));
    add("z2_alarm",    4'b0100, 1'b0, 1'b0, 1,  ex(ST_ALARM,      1'b1, 1'b0, 1'b1, 1'b0, 4'b0100, 1'b0));
    add("z2_disarm",   4'b0000, 1'b0, 1'b1, 1,  ex(ST_DISARMED,   1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0));
    add("settle1",     4'b0000, 1'b0, 1'b0, 12, ex(ST_DISARMED,   1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0));
    add("z1_open",     4'b0010, 1'b0, 1'b0, 12, ex(ST_DISARMED,   1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0));
    add("fault",       4'b0010, 1'b1, 1'b0, 1,  ex(ST_DISARMED,   1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0));
    add("fault_end",   4'b0010, 1'b0, 1'b0, 1,  ex(ST_DISARMED,   1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0));
    add("settle2",     4'b0000, 1'b0, 1'b0, 12, ex(ST_DISARMED,   1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0));
    add("rearm",       4'b0000, 1'b1, 1'b0, 16, ex(ST_EXIT_DELAY, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0));
    add("armed2",      4'b0000, 1'b0, 1'b0, 1,  ex(ST_ARMED,      1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0));
    add("z0_edge10",   4'b0001, 1'b0, 1'b0, 10, ex(ST_ARMED,      1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0));
    add("entry",       4'b0001, 1'b0, 1'b0, 1,  ex(ST_ENTRY_DELAY,1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0));
    add("entry_last",  4'b0001, 1'b0, 1'b0, 15, ex(ST_ENTRY_DELAY,1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0));
    add("entry_alarm", 4'b0001, 1'b0, 1'b0, 1,  ex(ST_ALARM,      1'b1, 1'b0, 1'b1, 1'b0, 4'b0001, 1'b0));
    add("arm_disarm",  4'b0001, 1'b1, 1'b1, 1,  ex(ST_DISARMED,   1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0));
    add("settle3",     4'b0000, 1'b0, 1'b0, 12, ex(ST_DISARMED,   1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0));
    add("rearm3",      4'b0000, 1'b1, 1'b0, 17, ex(ST_ARMED,      1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0));
    add("z0_entry",    4'b0001, 1'b0, 1'b0, 11, ex(ST_ENTRY_DELAY,1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0));
    add("z3_edge10",   4'b1001, 1'b0, 1'b0, 10, ex(ST_ENTRY_DELAY,1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0));
    add("z3_alarm",    4'b1001, 1'b0, 1'b0, 1,  ex(ST_ALARM,      1'b1, 1'b0, 1'b1, 1'b0, 4'b1001, 1'b0));
    add("z3_disarm",   4'b0000, 1'b0, 1'b1, 1,  ex(ST_DISARMED,   1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0));
    add("settle4",     4'b0000, 1'b0, 1'b0, 12, ex(ST_DISARMED,   1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0));

    repeat (3) @(posedge clk);
    #1;
    check("reset", 12'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      bus.sensor_raw = vecs[i].sensor;
      bus.arm_req    = vecs[i].arm;
      bus.disarm_req = vecs[i].disarm;
      tick();
      bus.arm_req    = 1'b0;
      bus.disarm_req = 1'b0;
      repeat (vecs[i].ncyc - 1) tick();
      check(vecs[i].name, vecs[i].exp);
    end

    // Asynchronous reset in the middle of the exit delay
    bus.arm_req = 1'b1;
    tick();
    bus.arm_req = 1'b0;
    repeat (3) tick();
    check("exit_before_rst", ex(ST_EXIT_DELAY, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0));
    #2 rst = 1'b1;
    #1 check("async_rst", 12'b0);
    #2 rst = 1'b0;
    tick();
    check("after_rst", 12'b0);

`ifdef INTRUSION_TAMPER_EN
    bus.tamper = 1'b1;
    repeat (12) tick();
    check("tamper_set", ex(ST_DISARMED, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1));
    bus.disarm_req = 1'b1;
    tick();
    bus.disarm_req = 1'b0;
    check("tamper_hold", ex(ST_DISARMED, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1));
    bus.tamper = 1'b0;
    repeat (12) tick();
    check("tamper_released", ex(ST_DISARMED, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1));
    bus.disarm_req = 1'b1;
    tick();
    bus.disarm_req = 1'b0;
    check("tamper_cleared", 12'b0);
`else
    bus.tamper = 1'b1;
    repeat (14) tick();
    check("tamper_ignored", 12'b0);
    bus.tamper = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
